// File: rtl/cby_param_ccff.sv
// rtl/cby_param_ccff.sv - Y-channel connection block with scan-chain configured ipin muxes
module cby_param_ccff #(
    parameter int CHAN_W    = 9,
    parameter int NUM_IPIN  = 11,
    parameter int FC_TRACKS = 3,
    parameter int STRIDE    = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                ccff_en,
    input  logic                ccff_head,
    input  logic [0:CHAN_W-1]   chany_bottom_in,
    input  logic [0:CHAN_W-1]   chany_top_in,
    output logic [0:CHAN_W-1]   chany_top_out,
    output logic [0:CHAN_W-1]   chany_bottom_out,
    output logic [NUM_IPIN-1:0] grid_pin,
    output logic                ccff_tail,
    output logic                cfg_done
);

    localparam int MUX_N     = 2 * FC_TRACKS;
    localparam int SEL_W     = $clog2(MUX_N);
    localparam int CFG_BITS  = NUM_IPIN * SEL_W;
    localparam int CNT_W     = $clog2(CFG_BITS + 1);
    localparam int MUX_SLOTS = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

    logic [CFG_BITS-1:0] cfg;
    logic [CNT_W-1:0]    shift_cnt;

    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    // Chain keeps shifting after done so instances further down can still load.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            cfg       <= '0;
            shift_cnt <= '0;
            cfg_done  <= 1'b0;
        end else if (ccff_en) begin
            cfg <= {cfg[CFG_BITS-2:0], ccff_head};
            if (shift_cnt != CNT_MAX)
                shift_cnt <= shift_cnt + 1'b1;
            if (shift_cnt == CNT_LAST)
                cfg_done <= 1'b1;
        end
    end

    assign ccff_tail = cfg[CFG_BITS-1];

    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
        logic [MUX_SLOTS-1:0] mux_in;
        logic [SEL_W-1:0]     sel;

        assign sel = cfg[k*SEL_W +: SEL_W];

        // Unused select codes map to constant-zero slots.
        for (genvar i = 0; i < MUX_SLOTS; i++) begin : g_slot
            localparam int TAP = (k + (i / 2) * STRIDE) % CHAN_W;
            if (i >= MUX_N) begin : g_zero
                assign mux_in[i] = 1'b0;
            end else if (i % 2 == 0) begin : g_bot
                assign mux_in[i] = chany_bottom_in[TAP];
            end else begin : g_top
                assign mux_in[i] = chany_top_in[TAP];
            end
        end

        assign grid_pin[k] = cfg_done & mux_in[sel];
    end

endmodule

// File: tb/tb_cby_param_ccff.sv
// tb/tb_cby_param_ccff.sv - directed table-driven bench for cby_param_ccff
module tb_cby_param_ccff;

    logic        prog_clk;
    logic        pReset;
    logic        ccff_en;
    logic        ccff_head;
    logic [0:8]  chany_bottom_in;
    logic [0:8]  chany_top_in;
    logic [0:8]  chany_top_out;
    logic [0:8]  chany_bottom_out;
    logic [10:0] grid_pin;
    logic        ccff_tail;
    logic        cfg_done;

    int errors = 0;
    int checks = 0;

    cby_param_ccff dut (
        .prog_clk         (prog_clk),
        .pReset           (pReset),
        .ccff_en          (ccff_en),
        .ccff_head        (ccff_head),
        .chany_bottom_in  (chany_bottom_in),
        .chany_top_in     (chany_top_in),
        .chany_top_out    (chany_top_out),
        .chany_bottom_out (chany_bottom_out),
        .grid_pin         (grid_pin),
        .ccff_tail        (ccff_tail),
        .cfg_done         (cfg_done)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [0:8]  bot;
        logic [0:8]  top;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs1[6];
    vec_t vecs2[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_reset();
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
    endtask

    task automatic shift(input logic b);
        ccff_en   = 1'b1;
        ccff_head = b;
        tick();
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    // First bit shifted ends in cfg[32], so walk the image from the top down.
    task automatic load(input logic [32:0] img);
        for (int i = 32; i >= 0; i--) shift(img[i]);
    endtask

    task automatic apply(input string name, input vec_t v);
        chany_bottom_in = v.bot;
        chany_top_in    = v.top;
        #1;
        check(name, 32'(grid_pin), 32'(v.exp));
    endtask

    logic [32:0] img;

    initial begin
        pReset = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0;
        chany_bottom_in = 9'h155; chany_top_in = 9'h0AA;

        // Config 1: ipin0 sel=2 (bottom[4]), ipin1 sel=7 (zero), rest sel=0 (bottom[k mod 9]).
        vecs1[0] = '{bot: 9'h1FF, top: 9'h000, exp: 11'h7FD};
        vecs1[1] = '{bot: 9'h000, top: 9'h1FF, exp: 11'h000};
        vecs1[2] = '{bot: 9'h155, top: 9'h0AA, exp: 11'h355};
        vecs1[3] = '{bot: 9'h0AA, top: 9'h155, exp: 11'h4A8};
        vecs1[4] = '{bot: 9'h100, top: 9'h1FF, exp: 11'h200};
        vecs1[5] = '{bot: 9'h010, top: 9'h000, exp: 11'h011};
        // Config 2: ipin2 sel=3 (top[6]), ipin3 sel=5 (top[2]), ipin4 sel=4 (bottom[3]).
        vecs2[0] = '{bot: 9'h000, top: 9'h004, exp: 11'h004};
        vecs2[1] = '{bot: 9'h000, top: 9'h040, exp: 11'h008};
        vecs2[2] = '{bot: 9'h020, top: 9'h000, exp: 11'h010};

        // Reset and pass-through during reset
        pReset = 1'b1;
        #1;
        check("pass_top_in_reset", 32'(chany_top_out), 32'h155);
        check("pass_bot_in_reset", 32'(chany_bottom_out), 32'h0AA);
        tick();
        pReset = 1'b0;
        chany_bottom_in = 9'h1FF; chany_top_in = 9'h1FF;
        tick(); tick();
        check("reset_done", 32'(cfg_done), 32'd0);
        check("reset_tail", 32'(ccff_tail), 32'd0);
        check("reset_grid", 32'(grid_pin), 32'd0);
        chany_bottom_in = 9'h0AA; chany_top_in = 9'h155;
        #1;
        check("pass_top", 32'(chany_top_out), 32'h0AA);
        check("pass_bot", 32'(chany_bottom_out), 32'h155);

        // Config 1 load with done timing
        img = '0;
        img[2:0] = 3'd2;
        img[5:3] = 3'd7;
        for (int i = 32; i >= 1; i--) shift(img[i]);
        check("done_before_33", 32'(cfg_done), 32'd0);
        chany_bottom_in = 9'h1FF;
        #1;
        check("grid_gated_partial", 32'(grid_pin), 32'd0);
        shift(img[0]);
        check("done_at_33", 32'(cfg_done), 32'd1);
        for (int i = 0; i < 6; i++) apply($sformatf("cfg1_vec%0d", i), vecs1[i]);

        // Holding ccff_en low keeps the configuration
        tick(); tick(); tick();
        apply("cfg1_hold", vecs1[2]);

        // Config 2 exercises top-track and later-tap selects
        do_reset();
        img = '0;
        img[8:6]   = 3'd3;
        img[11:9]  = 3'd5;
        img[14:12] = 3'd4;
        load(img);
        check("cfg2_done", 32'(cfg_done), 32'd1);
        for (int i = 0; i < 3; i++) apply($sformatf("cfg2_vec%0d", i), vecs2[i]);

        // Chain latency and counter saturation
        do_reset();
        shift(1'b1);
        for (int e = 2; e <= 40; e++) begin
            shift(1'b0);
            if (e == 32) check("tail_edge32", 32'(ccff_tail), 32'd0);
            if (e == 33) check("tail_edge33", 32'(ccff_tail), 32'd1);
            if (e == 34) check("tail_edge34", 32'(ccff_tail), 32'd0);
            if (e >= 33) check($sformatf("done_edge%0d", e), 32'(cfg_done), 32'd1);
        end

        // Reset wins over a simultaneous shift
        ccff_en = 1'b1; ccff_head = 1'b1; pReset = 1'b1;
        tick();
        pReset = 1'b0; ccff_en = 1'b0; ccff_head = 1'b0;
        check("prio_done", 32'(cfg_done), 32'd0);
        check("prio_tail", 32'(ccff_tail), 32'd0);

        // Reset mid-load discards the partial count
        for (int i = 0; i < 20; i++) shift(1'b1);
        do_reset();
        for (int i = 0; i < 32; i++) shift(1'b0);
        check("midload_32", 32'(cfg_done), 32'd0);
        shift(1'b0);
        check("midload_33", 32'(cfg_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cby_param_ccff.md
CBY_PARAM_CCFF -- requirements
Module: cby_param_ccff

Interface
REQ-001 SHALL have parameter CHAN_W, default 9, tracks per direction.
REQ-002 SHALL have parameter NUM_IPIN, default 11, grid input pins served.
REQ-003 SHALL have parameter FC_TRACKS, default 3, tracks tapped per ipin; mux size 2*FC_TRACKS.
REQ-004 SHALL have parameter STRIDE, default 4, track spacing between taps of one ipin.
REQ-005 SHALL derive SEL_W = clog2(2*FC_TRACKS) and CFG_BITS = NUM_IPIN*SEL_W; defaults give 3 and 33.
REQ-006 SHALL have port prog_clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port pReset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port ccff_en  input  1  config shift enable.
REQ-009 SHALL have port ccff_head  input  1  config chain serial in.
REQ-010 SHALL have ports chany_bottom_in and chany_top_in  input  CHAN_W  routing tracks, bit order [0:CHAN_W-1].
REQ-011 SHALL have ports chany_top_out and chany_bottom_out  output  CHAN_W  pass-through tracks.
REQ-012 SHALL have port grid_pin  output  NUM_IPIN  connection-block outputs to the adjacent grid.
REQ-013 SHALL have port ccff_tail  output  1  config chain serial out.
REQ-014 SHALL have port cfg_done  output  1  high once a full chain load has completed.

Function
REQ-015 SHALL drive chany_top_out = chany_bottom_in and chany_bottom_out = chany_top_in combinationally, independent of config and reset.
REQ-016 SHALL assign ipin k the taps t_j = (k + j*STRIDE) mod CHAN_W, for j = 0..FC_TRACKS-1.
REQ-017 SHALL order ipin k's mux inputs as index 2j = chany_bottom_in[t_j] and index 2j+1 = chany_top_in[t_j].
REQ-018 SHALL select ipin k's input by sel_k = cfg[k*SEL_W +: SEL_W], with the LSB at the lower cfg index.
REQ-019 SHALL drive grid_pin[k] to 0 when sel_k >= 2*FC_TRACKS.
REQ-020 SHALL make the grid_pin data path combinational from the chany inputs: zero cycles of latency.
REQ-021 SHALL hold cfg as a CFG_BITS shift register; when ccff_en=1, each edge loads cfg[0] <= ccff_head and cfg[i] <= cfg[i-1]; when ccff_en=0, cfg holds.
REQ-022 SHALL drive ccff_tail = cfg[CFG_BITS-1] as a registered value, so a bit entering at ccff_head appears at ccff_tail CFG_BITS enabled edges later.
REQ-023 SHALL keep a shift counter, width clog2(CFG_BITS+1), that increments on each enabled edge and saturates at CFG_BITS (no wrap).
REQ-024 SHALL set cfg_done=1 on the edge where the counter reaches CFG_BITS; cfg_done then stays 1 until reset.
REQ-025 SHALL continue shifting after cfg_done=1, so downstream blocks on the chain can still load; cfg_done remains 1.
REQ-026 SHALL force every grid_pin to 0 while cfg_done=0, gating partially loaded selects.
REQ-027 SHALL leave ccff_head/ccff_tail chaining rules unchanged when multiple instances are daisy-chained.

Reset
REQ-028 SHALL, when pReset=1 at an edge, clear cfg to all 0, the counter to 0, cfg_done to 0 and ccff_tail to 0; grid_pin is then all 0.
REQ-029 SHALL give pReset priority over ccff_en when both are asserted at the same edge.
REQ-030 SHALL, on reset mid-load, discard the partial load; a fresh load then needs a full CFG_BITS shifts.

Verification
REQ-031 Reset check: with defaults, assert pReset for 1 edge, then hold ccff_en=0 -> cfg_done=0, ccff_tail=0, grid_pin=0 for any chany inputs.
REQ-032 Pass-through check: chany_bottom_in=9'h155, chany_top_in=9'h0AA -> chany_top_out=9'h155 and chany_bottom_out=9'h0AA in the same cycle, including during reset.
REQ-033 Select check: shift 33 bits so only ipin0 sel=2 -> cfg_done rises on the 33rd edge; grid_pin[0] follows chany_bottom_in[4]; all other pins follow chany_bottom_in[t_0].
REQ-034 Out-of-range select check: ipin1 sel=7 -> grid_pin[1]=0 for all inputs.
REQ-035 Chain latency and saturation check: after reset, shift a single 1 followed by 0s -> ccff_tail=1 exactly after enabled edge 33; cfg_done stays 1 through edge 40.
REQ-036 Reset mid-load check: reset after 20 shifts, then 32 shifts -> cfg_done=0; the 33rd shift sets cfg_done=1.
